// File: rtl/descriptor_fetcher_if.sv
// rtl/descriptor_fetcher_if.sv - memory master and descriptor stream bundle for descriptor_fetcher
interface descriptor_fetcher_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              desc_valid;
    logic [127:0]      desc_data;
    logic              desc_ready;

    modport master (
        output m_address, m_chipselect, m_write, m_byteenable, m_writedata,
        input  m_readdata,
        output desc_valid, desc_data,
        input  desc_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_write, m_byteenable, m_writedata,
        output m_readdata,
        input  desc_valid, desc_data,
        output desc_ready
    );
endinterface

// File: rtl/descriptor_fetcher.sv
// rtl/descriptor_fetcher.sv - walks an owned-bit descriptor ring, streams each descriptor and clears its owned bit
module descriptor_fetcher #(
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [IDX_W-1:0]     start_index,
    input  logic                 abort,
    output logic                 busy,
    output logic                 status_empty,
    output logic [7:0]           desc_count,
    descriptor_fetcher_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_WRITEBACK
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       w_q, w_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic [127:0]     data_q, data_d;
    logic [IDX_W+1:0] word_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        w_d              = w_q;
        cnt_d            = cnt_q;
        empty_d          = empty_q;
        data_d           = data_q;
        word_addr        = '0;
        bus.m_chipselect = 1'b0;
        bus.m_write      = 1'b0;
        bus.m_byteenable = 4'b0000;
        bus.m_writedata  = '0;
        bus.desc_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    idx_d   = start_index;
                    cnt_d   = '0;
                    empty_d = 1'b0;
                    w_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.m_chipselect = 1'b1;
                bus.m_byteenable = 4'b1111;
                word_addr        = {idx_q, w_q};
                // Read data lags its address by one cycle, so this edge captures word w-1.
                case (w_q)
                    2'd1:    data_d[31:0]  = bus.m_readdata;
                    2'd2:    data_d[63:32] = bus.m_readdata;
                    2'd3:    data_d[95:64] = bus.m_readdata;
                    default: ;
                endcase
                w_d = w_q + 2'd1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_q == 2'd3) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                data_d[127:96] = bus.m_readdata;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!data_q[31]) begin
                    empty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                bus.desc_valid = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus.desc_ready) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                bus.m_chipselect = 1'b1;
                bus.m_write      = 1'b1;
                bus.m_byteenable = 4'b1000;
                word_addr        = {idx_q, 2'b00};
                bus.m_writedata  = {1'b0, data_q[30:24], 24'h000000};
                // The write always completes; abort only decides where to go afterwards.
                cnt_d            = cnt_q + 8'd1;
                idx_d            = idx_q + 1'b1;
                w_d              = '0;
                state_d          = abort ? S_IDLE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        bus.m_address = ADDR_W'(word_addr);
    end

    assign busy          = (state_q != S_IDLE);
    assign status_empty  = empty_q;
    assign desc_count    = cnt_q;
    assign bus.desc_data = data_q;
endmodule

// File: tb/tb_descriptor_fetcher.sv
// tb/tb_descriptor_fetcher.sv - scoreboard bench for descriptor_fetcher
module tb_descriptor_fetcher;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] start_index = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       status_empty;
    logic [7:0] desc_count;

    descriptor_fetcher_if #(.ADDR_W(9)) bus ();

    descriptor_fetcher #(.ADDR_W(9), .IDX_W(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .start_index (start_index),
        .abort       (abort),
        .busy        (busy),
        .status_empty(status_empty),
        .desc_count  (desc_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem [512];
    int           exp_rd[$];
    logic [127:0] exp_desc[$];
    int           exp_wr_addr[$];
    logic [7:0]   exp_wr_byte[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dw(input int d, input int w, input bit owned);
        logic [6:0] d7;
        logic [7:0] w8;
        d7 = d[6:0];
        w8 = w[7:0];
        return {(w == 0) ? owned : 1'b1, d7, w8, 16'hBEEF};
    endfunction

    task automatic set_desc(input int d, input bit owned);
        for (int w = 0; w < 4; w++) mem[4*d+w] = dw(d, w, owned);
    endtask

    task automatic expect_desc(input int d);
        logic [6:0] d7;
        d7 = d[6:0];
        exp_desc.push_back({mem[4*d+3], mem[4*d+2], mem[4*d+1], mem[4*d]});
        exp_wr_addr.push_back(4*d);
        exp_wr_byte.push_back({1'b0, d7});
    endtask

    task automatic expect_reads(input int d);
        for (int w = 0; w < 4; w++) exp_rd.push_back(4*d+w);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic pulse_start(input int idx);
        @(posedge clk); #1;
        start = 1'b1;
        start_index = idx[6:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 128'(busy), 128'(0));
    endtask

    task automatic check_queues(input string name);
        check({name, "_rd_left"},   128'(exp_rd.size()),      128'(0));
        check({name, "_desc_left"}, 128'(exp_desc.size()),    128'(0));
        check({name, "_wr_left"},   128'(exp_wr_addr.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  128'(busy),             128'(0));
        check({name, "_empty"}, 128'(status_empty),     128'(0));
        check({name, "_count"}, 128'(desc_count),       128'(0));
        check({name, "_addr"},  128'(bus.m_address),    128'(0));
        check({name, "_cs"},    128'(bus.m_chipselect), 128'(0));
        check({name, "_wr"},    128'(bus.m_write),      128'(0));
        check({name, "_be"},    128'(bus.m_byteenable), 128'(0));
        check({name, "_wdata"}, 128'(bus.m_writedata),  128'(0));
        check({name, "_valid"}, 128'(bus.desc_valid),   128'(0));
        check({name, "_data"},  bus.desc_data,          128'(0));
    endtask

    // Memory with one-cycle read latency and byte-enabled writes.
    initial begin
        bus.m_readdata = '0;
        forever begin
            @(posedge clk);
            if (reset_n && bus.m_chipselect) begin
                if (bus.m_write) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.m_byteenable[b]) mem[bus.m_address][8*b +: 8] = bus.m_writedata[8*b +: 8];
                end else begin
                    bus.m_readdata <= mem[bus.m_address];
                end
            end
        end
    end

    // Scoreboard monitor: every bus cycle and every descriptor transfer is matched against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.m_chipselect && !bus.m_write) begin
                    if (exp_rd.size() == 0) check("rd_unexpected", 128'(bus.m_address), 128'h1FFFF);
                    else check("rd_addr", 128'(bus.m_address), 128'(exp_rd.pop_front()));
                end
                if (bus.m_chipselect && bus.m_write) begin
                    if (exp_wr_addr.size() == 0) begin
                        check("wr_unexpected", 128'(bus.m_address), 128'h1FFFF);
                    end else begin
                        check("wr_addr", 128'(bus.m_address), 128'(exp_wr_addr.pop_front()));
                        check("wr_be", 128'(bus.m_byteenable), 128'(4'b1000));
                        check("wr_byte", 128'(bus.m_writedata[31:24]), 128'(exp_wr_byte.pop_front()));
                    end
                end
                if (bus.desc_valid && bus.desc_ready) begin
                    if (exp_desc.size() == 0) check("desc_unexpected", bus.desc_data, '1);
                    else check("desc_data", bus.desc_data, exp_desc.pop_front());
                end
            end
        end
    end

    initial begin
        bus.desc_ready = 1'b0;
        clear_mem();
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Three owned descriptors then an empty one.
        clear_mem();
        for (int d = 0; d < 3; d++) set_desc(d, 1'b1);
        set_desc(3, 1'b0);
        for (int d = 0; d < 3; d++) expect_desc(d);
        for (int d = 0; d < 4; d++) expect_reads(d);
        bus.desc_ready = 1'b1;
        pulse_start(0);
        wait_idle("seq");
        check("seq_empty", 128'(status_empty), 128'(1));
        check("seq_count", 128'(desc_count), 128'(3));
        check("seq_own0", 128'(mem[0][31]), 128'(0));
        check("seq_own1", 128'(mem[4][31]), 128'(0));
        check("seq_own2", 128'(mem[8][31]), 128'(0));
        check_queues("seq");

        // Index wrap from 127 to 0.
        clear_mem();
        set_desc(127, 1'b1);
        set_desc(0, 1'b1);
        set_desc(1, 1'b0);
        expect_desc(127);
        expect_desc(0);
        expect_reads(127);
        expect_reads(0);
        expect_reads(1);
        pulse_start(127);
        wait_idle("wrap");
        check("wrap_empty", 128'(status_empty), 128'(1));
        check("wrap_count", 128'(desc_count), 128'(2));
        check("wrap_own127", 128'(mem[508][31]), 128'(0));
        check_queues("wrap");

        // Latency, back-pressure and start-while-busy.
        clear_mem();
        set_desc(5, 1'b1);
        set_desc(6, 1'b0);
        expect_desc(5);
        expect_reads(5);
        expect_reads(6);
        bus.desc_ready = 1'b0;
        pulse_start(5);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("lat_addr", 128'(bus.m_address), 128'(19 + c));
            check("lat_cs", 128'({bus.m_chipselect, bus.m_write, bus.m_byteenable}), 128'(6'b10_1111));
        end
        @(negedge clk);
        check("lat_c5_cs", 128'(bus.m_chipselect), 128'(0));
        check("lat_c5_valid", 128'(bus.desc_valid), 128'(0));
        @(negedge clk);
        check("lat_c6_valid", 128'(bus.desc_valid), 128'(1));
        @(posedge clk); #1;
        start = 1'b1;
        start_index = 7'd0;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 8; c <= 16; c++) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.desc_valid), 128'(1));
            check("bp_data", bus.desc_data, {mem[23], mem[22], mem[21], mem[20]});
            check("bp_cs", 128'(bus.m_chipselect), 128'(0));
        end
        @(posedge clk); #1;
        bus.desc_ready = 1'b1;
        @(negedge clk);
        check("bp_rdy_cs", 128'(bus.m_chipselect), 128'(0));
        @(negedge clk);
        check("bp_wb", 128'({bus.m_chipselect, bus.m_write, bus.m_address}), 128'({2'b11, 9'd20}));
        wait_idle("bp");
        check("bp_count", 128'(desc_count), 128'(1));
        check("bp_empty", 128'(status_empty), 128'(1));
        check_queues("bp");

        // Abort while presenting.
        clear_mem();
        set_desc(10, 1'b1);
        expect_reads(10);
        bus.desc_ready = 1'b0;
        pulse_start(10);
        for (int n = 0; n < 20 && !bus.desc_valid; n++) @(negedge clk);
        check("ab_reach_valid", 128'(bus.desc_valid), 128'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_valid", 128'(bus.desc_valid), 128'(0));
        check("ab_busy", 128'(busy), 128'(0));
        check("ab_cs", 128'(bus.m_chipselect), 128'(0));
        check("ab_own", 128'(mem[40][31]), 128'(1));
        check("ab_count", 128'(desc_count), 128'(0));
        check_queues("ab");

        // Abort together with start in IDLE.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abst_busy", 128'(busy), 128'(0));

        // Reset in the second FETCH cycle.
        clear_mem();
        set_desc(5, 1'b1);
        exp_rd.push_back(20);
        bus.desc_ready = 1'b1;
        pulse_start(5);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 128'(busy), 128'(0));
        check("post_reset_own", 128'(mem[20][31]), 128'(1));
        check_queues("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
